booth_ctrl: RTL and testbench

- Control unit (sequencer) for the radix-2 Booth multiplier datapath.
- Directly upstream of the A/Q/M registers and the adder. Generates the one-cycle control strobes c0..c6 and the add/subtract select.
- Walks through load, N test/add/shift iterations and result readout.
- Decisions use Q[0] and Q[-1], which the datapath feeds back.

---
 rtl/booth_ctrl.sv | 150 +++++++++++++++
 tb/tb_booth_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : booth_ctrl
//  Purpose  : Sequencer for a radix-2 Booth multiplier datapath. Issues the
//             one-cycle strobes c0..c6 and the add/subtract select while it
//             walks load, N test/add/shift iterations and the result readout.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_b,
    input  logic start,
    input  logic q0,
    input  logic q_m1,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic c3,
    output logic c4,
    output logic c5,
    output logic c6,
    output logic sub,
    output logic busy,
    output logic done
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_LOAD_Q = 4'd2,
        S_TEST   = 4'd3,
        S_ADD    = 4'd4,
        S_SUB    = 4'd5,
        S_SHIFT  = 4'd6,
        S_OUT_A  = 4'd7,
        S_OUT_Q  = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    // Counter value seen in the SHIFT of the final iteration
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              start_q, start_d;

    logic c0_q, c1_q, c2_q, c3_q, c4_q, c5_q, c6_q, sub_q, busy_q, done_q;
    logic c0_d, c1_d, c2_d, c3_d, c4_d, c5_d, c6_d, sub_d, busy_d, done_d;

    // Next-state and iteration counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (start_q) state_d = S_INIT;
            S_INIT: begin
                cnt_d   = '0;
                state_d = S_LOAD_Q;
            end
            S_LOAD_Q: state_d = S_TEST;
            S_TEST: begin
                case ({q0, q_m1})
                    2'b10:   state_d = S_SUB;
                    2'b01:   state_d = S_ADD;
                    default: state_d = S_SHIFT;
                endcase
            end
            S_ADD:    state_d = S_SHIFT;
            S_SUB:    state_d = S_SHIFT;
            S_SHIFT: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_LAST) ? S_OUT_A : S_TEST;
            end
            S_OUT_A:  state_d = S_OUT_Q;
            S_OUT_Q:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Start request is captured only on edges that land in IDLE, so requests
    // made while busy are dropped and a held start relaunches after one IDLE cycle
    always_comb begin
        start_d = start && (state_d == S_IDLE);
    end

    // Output strobes decoded from the next state so the registered outputs
    // line up exactly with the cycles spent in each state
    always_comb begin
        c0_d   = (state_d == S_INIT);
        c1_d   = (state_d == S_INIT);
        c2_d   = (state_d == S_LOAD_Q);
        c3_d   = (state_d == S_ADD) || (state_d == S_SUB);
        sub_d  = (state_d == S_SUB);
        c4_d   = (state_d == S_SHIFT);
        c5_d   = (state_d == S_OUT_A);
        c6_d   = (state_d == S_OUT_Q);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State, counter and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            c3_q    <= 1'b0;
            c4_q    <= 1'b0;
            c5_q    <= 1'b0;
            c6_q    <= 1'b0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            c4_q    <= c4_d;
            c5_q    <= c5_d;
            c6_q    <= c6_d;
            sub_q   <= sub_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign c0   = c0_q;
    assign c1   = c1_q;
    assign c2   = c2_q;
    assign c3   = c3_q;
    assign c4   = c4_q;
    assign c5   = c5_q;
    assign c6   = c6_q;
    assign sub  = sub_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_ctrl
//  Purpose  : Self-checking bench for booth_ctrl: vector table of constant and
//             datapath-driven Booth runs, plus held-start and async-reset cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic start = 1'b0;
    logic q0_in, qm1_in;
    logic c0, c1, c2, c3, c4, c5, c6, sub, busy, done;

    // Stimulus source for q0/q_m1: constants or the datapath model
    logic use_dp = 1'b0;
    logic q0_c = 1'b0, qm1_c = 1'b0;

    // Minimal A/Q/M datapath model driven by the strobes
    logic [7:0] dp_a = '0, dp_q = '0, dp_m = '0;
    logic       dp_qm1 = 1'b0;
    logic [7:0] mbus = 8'd3, qbus = 8'hFB;

    int checks = 0;
    int errors = 0;

    assign q0_in  = use_dp ? dp_q[0] : q0_c;
    assign qm1_in = use_dp ? dp_qm1  : qm1_c;

    booth_ctrl #(.N(N), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .q0    (q0_in),
        .q_m1  (qm1_in),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4),
        .c5    (c5),
        .c6    (c6),
        .sub   (sub),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Datapath reacts to strobes at the clock edge ending each state
    always @(posedge clk) begin
        logic [16:0] aqq;
        aqq = {dp_a, dp_q, dp_qm1};
        if (c0) begin
            dp_a   <= '0;
            dp_qm1 <= 1'b0;
        end
        if (c1) dp_m <= mbus;
        if (c2) dp_q <= qbus;
        if (c3) dp_a <= sub ? (dp_a - dp_m) : (dp_a + dp_m);
        if (c4) begin
            aqq = $signed(aqq) >>> 1;
            {dp_a, dp_q, dp_qm1} <= aqq;
        end
    end

    typedef struct {
        logic        q0;
        logic        qm1;
        bit          dp;
        int          pulse;    // edge at which a stray start is pulsed, 0 = none
        int          k;        // expected ADD/SUB visits
        int          subs;     // expected SUB visits
        logic [15:0] ops;      // per-iteration op, 2 bits each: 0 none, 1 add, 2 sub
        logic [7:0]  exp_a;
        logic [7:0]  exp_q;
    } vec_t;

    // Event log of one operation
    int e_c0, e_c2, e_c5, e_c6, e_done;
    int n_c3, n_sub, n_c4, n_test, n_busy, n_viol, it_idx, cur_op;
    bit idle_after;
    logic [15:0] ops_seen;
    logic [7:0]  cap_a, cap_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic bit any_out();
        return c0 | c1 | c2 | c3 | c4 | c5 | c6 | sub | busy | done;
    endfunction

    task automatic log_edge(input int e);
        int act;
        act = int'(c0 | c1) + int'(c2) + int'(c3) + int'(c4) + int'(c5) + int'(c6) + int'(done);
        if (act > 1 || (c0 != c1) || (sub && !c3)) n_viol++;
        if (c0 && e_c0 < 0) e_c0 = e;
        if (c2 && e_c2 < 0) e_c2 = e;
        if (c5 && e_c5 < 0) e_c5 = e;
        if (c6 && e_c6 < 0) e_c6 = e;
        if (done && e_done < 0) e_done = e;
        if (e_done >= 0 && e == e_done + 1) idle_after = !any_out();
        if (busy) n_busy++;
        if (busy && act == 0) n_test++;
        if (c3) begin
            n_c3++;
            if (sub) n_sub++;
            cur_op = sub ? 2 : 1;
        end
        if (c4) begin
            if (it_idx < 8) ops_seen[it_idx*2 +: 2] = 2'(cur_op);
            it_idx++;
            cur_op = 0;
        end
        if (c5) cap_a = dp_a;
        if (c6) cap_q = dp_q;
    endtask

    task automatic run_op(input vec_t v);
        use_dp = v.dp;
        q0_c   = v.q0;
        qm1_c  = v.qm1;
        e_c0 = -1; e_c2 = -1; e_c5 = -1; e_c6 = -1; e_done = -1;
        n_c3 = 0; n_sub = 0; n_c4 = 0; n_test = 0; n_busy = 0; n_viol = 0;
        it_idx = 0; cur_op = 0; idle_after = 0; ops_seen = '0;
        cap_a = 'x; cap_q = 'x;
        start = 1'b1;
        step();                 // edge 0
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            start = (v.pulse != 0) && (e == v.pulse);
            step();
            start = 1'b0;
            if (c4) n_c4++;
            log_edge(e);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " c0 edge"},   e_c0, 1);
        chk({tag, " c2 edge"},   e_c2, 2);
        chk({tag, " c5 edge"},   e_c5, 3 + 2*N + v.k);
        chk({tag, " c6 edge"},   e_c6, 4 + 2*N + v.k);
        chk({tag, " done edge"}, e_done, 5 + 2*N + v.k);
        chk({tag, " c3 count"},  n_c3, v.k);
        chk({tag, " sub count"}, n_sub, v.subs);
        chk({tag, " c4 count"},  n_c4, N);
        chk({tag, " test cyc"},  n_test, N);
        chk({tag, " busy cyc"},  n_busy, 4 + 2*N + v.k);
        chk({tag, " excl viol"}, n_viol, 0);
        chk({tag, " ops"},       int'(ops_seen), int'(v.ops));
        chk({tag, " idle after"}, int'(idle_after), 1);
        if (v.dp) begin
            chk({tag, " obus A"}, int'(cap_a), int'(v.exp_a));
            chk({tag, " obus Q"}, int'(cap_q), int'(v.exp_q));
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   bad;
        logic [9:0] hist[0:24];

        // q0 q_m1 dp pulse k subs ops exp_a exp_q
        vecs[0] = '{1'b1, 1'b1, 1'b0, 0,  0, 0, 16'h0000, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 16'h0000, 8'h00, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 0,  8, 8, 16'hAAAA, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 10, 8, 0, 16'h5555, 8'h00, 8'h00};
        // M=3, Q=-5: recoding of FB gives sub, -, add, sub, -, -, -, -
        vecs[4] = '{1'b0, 1'b0, 1'b1, 0,  3, 2, 16'h0092, 8'hFF, 8'hF1};

        // Reset held, then released with start low
        repeat (3) step();
        chk("reset outputs", int'(any_out()), 0);
        rst_b = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (any_out()) bad++;
        end
        chk("idle outputs 10 cyc", bad, 0);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i]);
            check_vec($sformatf("vec%0d", i), vecs[i]);
            repeat (2) step();
        end

        // Start held high: back-to-back ops with one IDLE cycle between
        use_dp = 1'b0; q0_c = 1'b1; qm1_c = 1'b1;
        start = 1'b1;
        step();                 // edge 0
        for (int e = 1; e <= 24; e++) begin
            step();
            hist[e] = {c0, c2, c3, c4, c5, c6, sub, busy, done, 1'b0};
        end
        chk("held done@21", int'(hist[21][1]), 1);
        chk("held idle@22", int'(hist[22]), 0);
        chk("held init@23", int'(hist[23][9]), 1);
        chk("held busy@23", int'(hist[23][2]), 1);
        start = 1'b0;

        // Async reset while in SUB of a fresh operation
        rst_b = 1'b0;
        #3;
        rst_b = 1'b1;
        step();
        q0_c = 1'b1; qm1_c = 1'b0;
        start = 1'b1;
        step();                 // edge 0
        start = 1'b0;
        repeat (4) step();      // edge 4: SUB
        chk("pre-reset c3", int'(c3 & sub & busy), 1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("async c3 drop",   int'(c3), 0);
        chk("async sub drop",  int'(sub), 0);
        chk("async busy drop", int'(busy), 0);
        #3;
        rst_b = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (any_out()) bad++;
        end
        chk("post-reset idle", bad, 0);
        run_op(vecs[0]);
        check_vec("post-reset", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
